seq_pattern_tx: RTL and testbench

- Serial pattern transmitter: the stimulus-side counterpart of the team's serial sequence detectors.
- Latches a programmable bit pattern and shifts it out MSB-first, one bit per clock, on a single-bit stream.
- Supports a repeat count and an idle gap between repetitions.
- `out_bit` connects directly to a detector's serial input bit; used for on-chip self-test of the detectors and as a reusable stream source.

---
 rtl/seq_pattern_tx.sv | 170 +++++++++++++++++
 tb/tb_seq_pattern_tx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: latches a bit pattern and shifts it out MSB-first,
// with optional repetitions separated by idle gaps. All outputs are registered.
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             out_bit,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       state_dbg
);

  // Stream handshake: out_valid has no ready; every cycle with out_valid=1 carries
  // exactly one pattern bit on out_bit, and out_bit is held 0 whenever out_valid=0.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(WIDTH);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_t           r_state, w_nxt_state;
  logic [WIDTH-1:0] r_pat, w_nxt_pat;
  logic [LEN_W-1:0] r_len, w_nxt_len;
  logic [GAP_W-1:0] r_gap_len, w_nxt_gap_len;
  logic [LEN_W-1:0] r_idx, w_nxt_idx;
  logic [CNT_W-1:0] r_rep_cnt, w_nxt_rep_cnt;
  logic [GAP_W-1:0] r_gap_cnt, w_nxt_gap_cnt;
  logic             r_out_bit, w_nxt_out_bit;
  logic             r_out_valid, w_nxt_out_valid;
  logic             r_busy, w_nxt_busy;
  logic             r_done, w_nxt_done;
  logic             r_err, w_nxt_err;

  logic             w_len_ok;
  logic [LEN_W-1:0] w_len_m1, w_rlen_m1, w_idx_m1;
  logic [WIDTH-1:0] w_in_v, w_first_v, w_next_v;

  // Bits are picked by shifting so the index width need not match log2(WIDTH).
  assign w_len_ok  = (len != '0) && (len <= MAX_LEN);
  assign w_len_m1  = len - 1'b1;
  assign w_rlen_m1 = r_len - 1'b1;
  assign w_idx_m1  = r_idx - 1'b1;
  assign w_in_v    = pattern >> w_len_m1;
  assign w_first_v = r_pat >> w_rlen_m1;
  assign w_next_v  = r_pat >> w_idx_m1;

  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_pat       = r_pat;
    w_nxt_len       = r_len;
    w_nxt_gap_len   = r_gap_len;
    w_nxt_idx       = r_idx;
    w_nxt_rep_cnt   = r_rep_cnt;
    w_nxt_gap_cnt   = r_gap_cnt;
    w_nxt_out_bit   = 1'b0;
    w_nxt_out_valid = 1'b0;
    w_nxt_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (w_len_ok) begin
            w_nxt_state     = S_SHIFT;
            w_nxt_pat       = pattern;
            w_nxt_len       = len;
            w_nxt_gap_len   = gap;
            w_nxt_idx       = w_len_m1;
            w_nxt_rep_cnt   = repeat_n;
            w_nxt_out_bit   = w_in_v[0];
            w_nxt_out_valid = 1'b1;
          end else begin
            w_nxt_err = 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (r_idx != '0) begin
          w_nxt_idx       = w_idx_m1;
          w_nxt_out_bit   = w_next_v[0];
          w_nxt_out_valid = 1'b1;
        end else if (r_rep_cnt != '0) begin
          if (r_gap_len != '0) begin
            w_nxt_state   = S_GAP;
            w_nxt_gap_cnt = r_gap_len;
          end else begin
            // Back-to-back repetition: restart at the top bit with no bubble.
            w_nxt_idx       = w_rlen_m1;
            w_nxt_out_bit   = w_first_v[0];
            w_nxt_out_valid = 1'b1;
            w_nxt_rep_cnt   = r_rep_cnt - 1'b1;
          end
        end else begin
          w_nxt_state = S_DONE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == GAP_ONE) begin
          w_nxt_state     = S_SHIFT;
          w_nxt_idx       = w_rlen_m1;
          w_nxt_out_bit   = w_first_v[0];
          w_nxt_out_valid = 1'b1;
          w_nxt_rep_cnt   = r_rep_cnt - 1'b1;
        end else begin
          w_nxt_gap_cnt = r_gap_cnt - 1'b1;
        end
      end
      S_DONE: begin
        w_nxt_state = S_IDLE;
      end
      default: begin
        w_nxt_state = S_IDLE;
      end
    endcase
    w_nxt_busy = (w_nxt_state != S_IDLE);
    w_nxt_done = (w_nxt_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pat       <= '0;
      r_len       <= '0;
      r_gap_len   <= '0;
      r_idx       <= '0;
      r_rep_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_out_bit   <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_pat       <= w_nxt_pat;
      r_len       <= w_nxt_len;
      r_gap_len   <= w_nxt_gap_len;
      r_idx       <= w_nxt_idx;
      r_rep_cnt   <= w_nxt_rep_cnt;
      r_gap_cnt   <= w_nxt_gap_cnt;
      r_out_bit   <= w_nxt_out_bit;
      r_out_valid <= w_nxt_out_valid;
      r_busy      <= w_nxt_busy;
      r_done      <= w_nxt_done;
      r_err       <= w_nxt_err;
    end
  end

  assign out_bit   = r_out_bit;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: directed transmissions, expected per-cycle output
// vectors {out_valid,out_bit,busy,done,err} queued by the driver, popped by a monitor.
module tb_seq_pattern_tx;

  localparam int WIDTH = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 4;
  localparam int GAP_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [CNT_W-1:0] repeat_n;
  logic [GAP_W-1:0] gap;
  logic             out_bit;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       state_dbg;

  logic [4:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  string      cur_name = "reset";

  seq_pattern_tx #(
    .WIDTH(WIDTH), .LEN_W(LEN_W), .CNT_W(CNT_W), .GAP_W(GAP_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len),
    .repeat_n(repeat_n), .gap(gap), .out_bit(out_bit), .out_valid(out_valid),
    .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every non-idle output cycle must match the head of the expected queue.
  task automatic monitor();
    logic [4:0] w;
    logic [4:0] e;
    forever begin
      @(negedge clk);
      w = {out_valid, out_bit, busy, done, err};
      if (w != 5'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL %s: unexpected output vector %b, expected idle", cur_name, w);
        end else begin
          e = exp_q.pop_front();
          if (w !== e) begin
            errors++;
            $display("FAIL %s: output vector %b expected %b", cur_name, w, e);
          end
        end
      end
    end
  endtask

  // Expected stream from the transmission rule: bits len-1..0, repeated,
  // gap idle busy cycles between repetitions, then one DONE cycle.
  task automatic push_expected(input logic [WIDTH-1:0] p, input int l, input int r, input int g);
    for (int k = 0; k <= r; k++) begin
      for (int i = l - 1; i >= 0; i--) exp_q.push_back({1'b1, p[i], 1'b1, 1'b0, 1'b0});
      if (k < r) for (int j = 0; j < g; j++) exp_q.push_back(5'b00100);
    end
    exp_q.push_back(5'b00110);
  endtask

  task automatic send(input string name, input logic [WIDTH-1:0] p, input int l,
                      input int r, input int g);
    @(negedge clk);
    cur_name = name;
    pattern  = p;
    len      = LEN_W'(l);
    repeat_n = CNT_W'(r);
    gap      = GAP_W'(g);
    push_expected(p, l, r, g);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bad(input string name, input int l);
    @(negedge clk);
    cur_name = name;
    pattern  = 8'hFF;
    len      = LEN_W'(l);
    exp_q.push_back(5'b00001);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: timeout, %0d expected vectors never seen", cur_name, exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b1;
    pattern  = 8'h0B;
    len      = 4'd4;
    repeat_n = '0;
    gap      = '0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    check("reset_out_valid", 8'(out_valid), 8'h0);
    check("reset_out_bit", 8'(out_bit), 8'h0);
    check("reset_busy", 8'(busy), 8'h0);
    check("reset_done", 8'(done), 8'h0);
    check("reset_err", 8'(err), 8'h0);
    check("reset_state", 8'(state_dbg), 8'h0);
    start = 1'b0;
    reset = 1'b0;

    send("single_0B", 8'h0B, 4, 0, 0);
    drain(50);
    send("b2b_0B_x3", 8'h0B, 4, 2, 0);
    drain(50);
    send("gap_0B_x2", 8'h0B, 4, 1, 2);
    drain(50);

    // Full width with start and pattern change in mid-shift: both ignored.
    send("ignore_A5", 8'hA5, 8, 0, 0);
    repeat (2) @(negedge clk);
    pattern = 8'hFF;
    len     = 4'd2;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    drain(50);

    send_bad("bad_len0", 0);
    drain(20);
    send_bad("bad_len9", 9);
    drain(20);
    send_bad("bad_len15", 15);
    drain(20);
    send("after_bad_101", 8'h05, 3, 0, 1);
    drain(50);

    // Maximum repeat and gap counts with a 1-bit pattern.
    send("max_rep_gap", 8'h01, 1, 15, 15);
    drain(400);
    send("len1_zero", 8'h00, 1, 1, 0);
    drain(50);

    // Reset after two bits have been presented.
    send("reset_mid", 8'h0B, 4, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_out_valid", 8'(out_valid), 8'h0);
    check("rst_mid_busy", 8'(busy), 8'h0);
    check("rst_mid_done", 8'(done), 8'h0);
    check("rst_mid_state", 8'(state_dbg), 8'h0);
    reset = 1'b0;
    send("after_reset_0B", 8'h0B, 4, 0, 0);
    drain(50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
